xenoa_temporal_mc: RTL and testbench
====================================

# xenoa_temporal_mc

Multi-domain temporal alignment block for the XENOA layer. It is the parametrised successor of the three-domain aligner:
- Tracks NUM_DOM independent timestamp sources from XR-BUS, each with its own strobe.
- Measures per-domain drift against the local clock and raises sticky, clearable warnings.
- Produces a monotonic aligned timestamp.
- Issues causal-chain IDs and saturating causal distances through a valid/ready handshake.

## Interface
- NUM_DOM, 3: number of timestamp domains (1..8)
- TS_W, 64: timestamp width
- CHAIN_W, 128: causal chain ID width
- DRIFT_W, 32: drift/elapsed counter width
- NOM_INC, 1: nominal timestamp ticks per clk
- DRIFT_THRESH, 100: drift warning threshold, ticks
- MAX_CAUSAL, 1000: causal distance ceiling
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ts_in  in  NUM_DOM*TS_W  packed domain timestamps; domain i at [i*TS_W +: TS_W]
- ts_valid  in  NUM_DOM  per-domain sample strobe
- warn_clr  in  NUM_DOM  per-domain sticky warning clear
- drift  out  NUM_DOM*DRIFT_W  last measured drift per domain
- drift_warn  out  NUM_DOM  sticky drift warning per domain
- aligned_ts  out  TS_W  aligned timestamp
- aligned_valid  out  1  one-cycle pulse on aligned_ts update
- chain_in_valid  in  1  parent chain presented
- chain_in_ready  out  1  block accepts parent
- parent_id  in  CHAIN_W  parent chain ID
- parent_dist  in  32  parent causal distance
- chain_out_valid  out  1  child chain available
- chain_out_ready  in  1  consumer accepts child
- chain_id  out  CHAIN_W  child chain ID
- causal_distance  out  32  child causal distance
- causal_sat  out  1  child distance was clamped

## Operation
- Per domain i, the following state is held:
  - seen flag, cleared at reset.
  - last_ts.
  - elapsed counter: counts clk cycles since the last sample, saturating at 2^DRIFT_W-1.
- First ts_valid[i] after reset:
  - Latch last_ts and set seen.
  - Clear elapsed to 1.
  - drift is unchanged (0).
- Subsequent ts_valid[i]:
  - delta = ts_in_i - last_ts, modulo 2^TS_W, so wrap is legal.
  - drift_i = |delta - elapsed*NOM_INC|, saturated to DRIFT_W.
  - drift_warn[i] is set if drift_i > DRIFT_THRESH.
  - last_ts is updated and elapsed restarts at 1.
- drift_warn[i] clears only on warn_clr[i]. A set condition in the same cycle as warn_clr[i] wins.
- aligned_ts:
  - When any ts_valid is high, take the maximum over domains that are either sampling this cycle or already seen. Domains that are sampling use ts_in; domains that are only seen use last_ts.
  - Register the result and pulse aligned_valid.
- Chain FSM, two states:
  - IDLE: chain_in_ready=1. On chain_in_valid, go to OUT with chain_id = parent_id + 1 (modulo 2^CHAIN_W).
  - Child distance in the same transition: causal_distance = min(parent_dist + 1, MAX_CAUSAL). causal_sat=1 when parent_dist >= MAX_CAUSAL.
  - OUT: chain_out_valid=1, outputs stable, chain_in_ready=0. On chain_out_ready, go to IDLE.
- Reset values of outputs:
  - drift = 0, drift_warn = 0.
  - aligned_ts = 0, aligned_valid = 0.
  - chain_out_valid = 0, chain_in_ready = 1.
  - chain_id = XENOA_CAUSAL_SEED (128'hA1B2_C3D4_E5F6_7890_1234_5678_9ABC_DEF0, truncated to CHAIN_W).
  - causal_distance = 0, causal_sat = 0.
- Reset mid-operation: any pending child is dropped; all seen flags clear.

## Timing
- drift and drift_warn update 1 cycle after ts_valid[i].
- aligned_ts and aligned_valid update 1 cycle after any ts_valid.
- Chain: the child is visible 1 cycle after the input handshake. Throughput is at most 1 chain per 2 cycles.
- warn_clr takes effect on the next edge.
- Simultaneous strobes on all domains are processed in the same cycle.

## Configuration
- Macro: XENOA_TEMPORAL_MONO_EN.
- Defined: aligned_ts never decreases. If a new maximum is below the current aligned_ts, hold the value, still pulse aligned_valid, and do not compare wrapped values.
- Undefined: aligned_ts takes the raw maximum on every update.

## Structure
- Package xenoa_temporal_pkg holds:
  - XENOA_CAUSAL_SEED
  - chain_state_e {IDLE, OUT}
  - saturating add/abs helper functions
- Sub-module xenoa_drift_chan holds one domain's seen flag, last_ts, elapsed counter, drift and sticky warning. It is instantiated NUM_DOM times by a generate loop.
- The top level holds the max tree, monotonic clamp and chain FSM.

## Test plan
- Bench configuration for all scenarios: NUM_DOM=3, NOM_INC=1.
- Domain 0 drift:
  - Stimulus: domain 0 samples 1000, then 1010 ten cycles later.
  - Required: drift=0, warn=0.
  - Stimulus: next sample 1220 ten cycles later.
  - Required: drift=200, drift_warn[0]=1 until warn_clr[0].
- Wrap:
  - Stimulus: domain 1 samples 2^64-5, then 5 ten cycles later.
  - Required: delta=10, drift=0.
- Max tree:
  - Stimulus: all domains sample 100/300/200 in the same cycle.
  - Required next cycle: aligned_ts=300, aligned_valid=1.
  - Stimulus: then domain 1 samples 250.
  - Required: aligned_ts=300 with MONO_EN, 250 without.
- Chain issue under backpressure:
  - Stimulus: parent_id=7, parent_dist=5, chain_out_ready held low 3 cycles.
  - Required: chain_id=8, causal_distance=6, stable while chain_in_ready=0; released on the ready cycle.
- Chain saturation:
  - Stimulus: parent_dist=1000.
  - Required: causal_distance=1000, causal_sat=1.
- Reset mid-operation:
  - Stimulus: assert rst_n low while in OUT.
  - Required: chain_out_valid=0, chain_id=seed, drift_warn=0.
  - Stimulus: next sample after reset.
  - Required: treated as first sample (no drift computed).

Source files
------------

// File: rtl/xenoa_temporal_pkg.sv
// Shared types, constants and helpers for the XENOA temporal alignment block.
// The causal seed is 128 bits wide and is truncated to the chain ID width where it is used.
package xenoa_temporal_pkg;

   localparam logic [127:0] XENOA_CAUSAL_SEED = 128'hA1B2_C3D4_E5F6_7890_1234_5678_9ABC_DEF0;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OUT  = 1'b1
   } chain_state_e;

   // Absolute difference of two unsigned values. The operands are zero-extended to 128 bits.
   function automatic logic [127:0] abs_diff(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] r;
      if (a >= b) begin
         r = a - b;
      end else begin
         r = b - a;
      end
      return r;
   endfunction

   // Clamp a value to a ceiling. This is the saturation step after an add or an abs.
   function automatic logic [127:0] sat_min(input logic [127:0] v, input logic [127:0] ceil);
      logic [127:0] r;
      if (v > ceil) begin
         r = ceil;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage

// File: rtl/xenoa_temporal_if.sv
// Causal-chain handshake bundle.
// The master modport is the parent producer and child consumer. The slave modport is the aligner.
interface xenoa_temporal_if #(
   parameter int CHAIN_W = 128
);
   logic               chain_in_valid;
   logic               chain_in_ready;
   logic [CHAIN_W-1:0] parent_id;
   logic [31:0]        parent_dist;
   logic               chain_out_valid;
   logic               chain_out_ready;
   logic [CHAIN_W-1:0] chain_id;
   logic [31:0]        causal_distance;
   logic               causal_sat;

   modport master (
      output chain_in_valid, parent_id, parent_dist, chain_out_ready,
      input  chain_in_ready, chain_out_valid, chain_id, causal_distance, causal_sat
   );

   modport slave (
      input  chain_in_valid, parent_id, parent_dist, chain_out_ready,
      output chain_in_ready, chain_out_valid, chain_id, causal_distance, causal_sat
   );
endinterface

// File: rtl/xenoa_drift_chan.sv
// Per-domain drift tracker. It holds the seen flag, the last timestamp, the elapsed counter,
// the measured drift and a sticky warning.
module xenoa_drift_chan
   import xenoa_temporal_pkg::*;
#(
   parameter int TS_W         = 64,
   parameter int DRIFT_W      = 32,
   parameter int NOM_INC      = 1,
   parameter int DRIFT_THRESH = 100
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [TS_W-1:0]    i_ts,
   input  logic               i_valid,
   input  logic               i_clr,
   output logic               o_seen,
   output logic [TS_W-1:0]    o_last_ts,
   output logic [DRIFT_W-1:0] o_drift,
   output logic               o_warn
);
   localparam logic [DRIFT_W-1:0] ELAPSED_MAX = {DRIFT_W{1'b1}};
   localparam logic [DRIFT_W-1:0] ELAPSED_ONE = DRIFT_W'(1);

   logic               r_seen;
   logic [TS_W-1:0]    r_last_ts;
   logic [DRIFT_W-1:0] r_elapsed;
   logic [DRIFT_W-1:0] r_drift;
   logic               r_warn;

   logic [TS_W-1:0]    w_delta;
   logic [127:0]       w_abs;
   logic [DRIFT_W-1:0] w_drift_sat;
   logic               w_over;

   // The delta wraps modulo 2^TS_W, so a source counter rolling over still reads as a small step.
   always_comb begin
      w_delta     = i_ts - r_last_ts;
      w_abs       = abs_diff(128'(w_delta), 128'(r_elapsed) * 128'(NOM_INC));
      w_drift_sat = DRIFT_W'(sat_min(w_abs, 128'(ELAPSED_MAX)));
      w_over      = (128'(w_drift_sat) > 128'(DRIFT_THRESH));
   end

   // Sample capture, elapsed counting and drift measurement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seen    <= 1'b0;
         r_last_ts <= '0;
         r_elapsed <= '0;
         r_drift   <= '0;
      end else if (i_valid) begin
         r_seen    <= 1'b1;
         r_last_ts <= i_ts;
         r_elapsed <= ELAPSED_ONE;
         if (r_seen) begin
            r_drift <= w_drift_sat;
         end
      end else if (r_seen && (r_elapsed != ELAPSED_MAX)) begin
         r_elapsed <= r_elapsed + ELAPSED_ONE;
      end
   end

   // Sticky warning. A new violation beats a clear that arrives in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_warn <= 1'b0;
      end else if (i_valid && r_seen && w_over) begin
         r_warn <= 1'b1;
      end else if (i_clr) begin
         r_warn <= 1'b0;
      end
   end

   assign o_seen    = r_seen;
   assign o_last_ts = r_last_ts;
   assign o_drift   = r_drift;
   assign o_warn    = r_warn;
endmodule

// File: rtl/xenoa_temporal_mc.sv
// Multi-domain temporal aligner: per-domain drift channels, aligned-timestamp max tree, causal-chain issuer.
// Optional XENOA_TEMPORAL_MONO_EN makes aligned_ts non-decreasing.
module xenoa_temporal_mc
   import xenoa_temporal_pkg::*;
#(
   parameter int NUM_DOM      = 3,
   parameter int TS_W         = 64,
   parameter int CHAIN_W      = 128,
   parameter int DRIFT_W      = 32,
   parameter int NOM_INC      = 1,
   parameter int DRIFT_THRESH = 100,
   parameter int MAX_CAUSAL   = 1000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_DOM*TS_W-1:0]    i_ts_in,
   input  logic [NUM_DOM-1:0]         i_ts_valid,
   input  logic [NUM_DOM-1:0]         i_warn_clr,
   output logic [NUM_DOM*DRIFT_W-1:0] o_drift,
   output logic [NUM_DOM-1:0]         o_drift_warn,
   output logic [TS_W-1:0]            o_aligned_ts,
   output logic                       o_aligned_valid,
   xenoa_temporal_if.slave            bus
);
   logic [NUM_DOM-1:0] w_seen;
   logic [TS_W-1:0]    w_last_ts [NUM_DOM];
   logic [TS_W-1:0]    w_cand    [NUM_DOM];
   logic [TS_W-1:0]    w_max;
   logic [TS_W-1:0]    w_next_aligned;

   logic [TS_W-1:0]    r_aligned_ts;
   logic               r_aligned_valid;

   for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
      xenoa_drift_chan #(
         .TS_W         (TS_W),
         .DRIFT_W      (DRIFT_W),
         .NOM_INC      (NOM_INC),
         .DRIFT_THRESH (DRIFT_THRESH)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_ts      (i_ts_in[g*TS_W +: TS_W]),
         .i_valid   (i_ts_valid[g]),
         .i_clr     (i_warn_clr[g]),
         .o_seen    (w_seen[g]),
         .o_last_ts (w_last_ts[g]),
         .o_drift   (o_drift[g*DRIFT_W +: DRIFT_W]),
         .o_warn    (o_drift_warn[g])
      );

      // An unseen, idle domain contributes 0, which is neutral in an unsigned max.
      assign w_cand[g] = i_ts_valid[g] ? i_ts_in[g*TS_W +: TS_W] :
                         (w_seen[g] ? w_last_ts[g] : '0);
   end

   // Max tree over the candidates, followed by the optional monotonic hold.
   always_comb begin
      w_max = '0;
      for (int i = 0; i < NUM_DOM; i++) begin
         if (w_cand[i] > w_max) begin
            w_max = w_cand[i];
         end else begin
            w_max = w_max;
         end
      end
`ifdef XENOA_TEMPORAL_MONO_EN
      if (w_max < r_aligned_ts) begin
         w_next_aligned = r_aligned_ts;
      end else begin
         w_next_aligned = w_max;
      end
`else
      w_next_aligned = w_max;
`endif
   end

   // Aligned timestamp register and its update pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_aligned_ts    <= '0;
         r_aligned_valid <= 1'b0;
      end else begin
         r_aligned_valid <= |i_ts_valid;
         if (|i_ts_valid) begin
            r_aligned_ts <= w_next_aligned;
         end
      end
   end

   assign o_aligned_ts    = r_aligned_ts;
   assign o_aligned_valid = r_aligned_valid;

   chain_state_e       r_state;
   chain_state_e       w_state_nxt;
   logic               w_load;
   logic [32:0]        w_dist_inc;
   logic [31:0]        w_child_dist;
   logic               w_child_sat;
   logic               r_out_valid;
   logic               r_in_ready;
   logic [CHAIN_W-1:0] r_chain_id;
   logic [31:0]        r_causal_distance;
   logic               r_causal_sat;

   // Chain FSM next state. The child is computed from the parent while in IDLE.
   always_comb begin
      w_state_nxt  = r_state;
      w_load       = 1'b0;
      w_dist_inc   = 33'(bus.parent_dist) + 33'd1;
      w_child_dist = 32'(sat_min(128'(w_dist_inc), 128'(MAX_CAUSAL)));
      w_child_sat  = (bus.parent_dist >= 32'(MAX_CAUSAL));
      case (r_state)
         IDLE: begin
            if (bus.chain_in_valid) begin
               w_state_nxt = OUT;
               w_load      = 1'b1;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         OUT: begin
            if (bus.chain_out_ready) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = OUT;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register. The handshake flags are registered copies of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_out_valid <= (w_state_nxt == OUT);
         r_in_ready  <= (w_state_nxt == IDLE);
      end
   end

   // Child payload registers. They load only on acceptance, so they stay stable while OUT stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chain_id        <= CHAIN_W'(XENOA_CAUSAL_SEED);
         r_causal_distance <= 32'd0;
         r_causal_sat      <= 1'b0;
      end else if (w_load) begin
         r_chain_id        <= bus.parent_id + CHAIN_W'(1);
         r_causal_distance <= w_child_dist;
         r_causal_sat      <= w_child_sat;
      end
   end

   assign bus.chain_in_ready  = r_in_ready;
   assign bus.chain_out_valid = r_out_valid;
   assign bus.chain_id        = r_chain_id;
   assign bus.causal_distance = r_causal_distance;
   assign bus.causal_sat      = r_causal_sat;
endmodule

// File: tb/tb_xenoa_temporal_mc.sv
// Directed self-checking bench for xenoa_temporal_mc (NUM_DOM=3, NOM_INC=1).
// Expected values track XENOA_TEMPORAL_MONO_EN.
module tb_xenoa_temporal_mc;
   localparam logic [127:0] SEED = 128'hA1B2_C3D4_E5F6_7890_1234_5678_9ABC_DEF0;

   logic          clk;
   logic          rst_n;
   logic [191:0]  ts_in;
   logic [2:0]    ts_valid;
   logic [2:0]    warn_clr;
   logic [95:0]   drift;
   logic [2:0]    drift_warn;
   logic [63:0]   aligned_ts;
   logic          aligned_valid;
   int            checks;
   int            errors;

   xenoa_temporal_if #(.CHAIN_W(128)) bus ();

   xenoa_temporal_mc #(
      .NUM_DOM(3), .TS_W(64), .CHAIN_W(128), .DRIFT_W(32),
      .NOM_INC(1), .DRIFT_THRESH(100), .MAX_CAUSAL(1000)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_ts_in         (ts_in),
      .i_ts_valid      (ts_valid),
      .i_warn_clr      (warn_clr),
      .o_drift         (drift),
      .o_drift_warn    (drift_warn),
      .o_aligned_ts    (aligned_ts),
      .o_aligned_valid (aligned_valid),
      .bus             (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic sample(input int d, input logic [63:0] v);
      ts_in[d*64 +: 64] = v;
      ts_valid = 3'b000;
      ts_valid[d] = 1'b1;
      step();
      ts_valid = 3'b000;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      ts_in = '0;
      ts_valid = 3'b000;
      warn_clr = 3'b000;
      bus.chain_in_valid = 1'b0;
      bus.parent_id = '0;
      bus.parent_dist = 32'd0;
      bus.chain_out_ready = 1'b0;
      reset_dut();

      // Reset state
      check("rst_drift", 128'(drift), 128'd0);
      check("rst_warn", 128'(drift_warn), 128'd0);
      check("rst_aligned", 128'(aligned_ts), 128'd0);
      check("rst_aligned_valid", 128'(aligned_valid), 128'd0);
      check("rst_out_valid", 128'(bus.chain_out_valid), 128'd0);
      check("rst_in_ready", 128'(bus.chain_in_ready), 128'd1);
      check("rst_chain_id", bus.chain_id, SEED);
      check("rst_cdist", 128'(bus.causal_distance), 128'd0);
      check("rst_csat", 128'(bus.causal_sat), 128'd0);

      // Domain 0 drift: 1000, then 1010 ten cycles later, then 1220 ten cycles later
      sample(0, 64'd1000);
      check("d0_first_drift", 128'(drift[31:0]), 128'd0);
      check("d0_first_aligned", 128'(aligned_ts), 128'd1000);
      check("d0_first_av", 128'(aligned_valid), 128'd1);
      idle(9);
      sample(0, 64'd1010);
      check("d0_nom_drift", 128'(drift[31:0]), 128'd0);
      check("d0_nom_warn", 128'(drift_warn[0]), 128'd0);
      idle(9);
      sample(0, 64'd1220);
      check("d0_big_drift", 128'(drift[31:0]), 128'd200);
      check("d0_big_warn", 128'(drift_warn[0]), 128'd1);
      idle(3);
      check("d0_warn_sticky", 128'(drift_warn[0]), 128'd1);
      warn_clr = 3'b001;
      step();
      warn_clr = 3'b000;
      check("d0_warn_cleared", 128'(drift_warn[0]), 128'd0);
      check("d0_drift_kept", 128'(drift[31:0]), 128'd200);

      // Wrap on domain 1: 2^64-5, then 5 ten cycles later
      sample(1, 64'hFFFF_FFFF_FFFF_FFFB);
      check("wrap_aligned_hi", 128'(aligned_ts), 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFB);
      idle(9);
      sample(1, 64'd5);
      check("wrap_drift", 128'(drift[63:32]), 128'd0);
      check("wrap_warn", 128'(drift_warn[1]), 128'd0);
      check("wrap_d0_untouched", 128'(drift[31:0]), 128'd200);
`ifdef XENOA_TEMPORAL_MONO_EN
      check("wrap_aligned", 128'(aligned_ts), 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFB);
`else
      check("wrap_aligned", 128'(aligned_ts), 128'd1220);
`endif

      // Max tree: 100/300/200 together, then domain 1 alone at 250
      reset_dut();
      ts_in = {64'd200, 64'd300, 64'd100};
      ts_valid = 3'b111;
      step();
      ts_valid = 3'b000;
      check("max_all", 128'(aligned_ts), 128'd300);
      check("max_all_av", 128'(aligned_valid), 128'd1);
      step();
      check("max_av_pulse", 128'(aligned_valid), 128'd0);
      sample(1, 64'd250);
      check("max_lower_av", 128'(aligned_valid), 128'd1);
`ifdef XENOA_TEMPORAL_MONO_EN
      check("max_lower", 128'(aligned_ts), 128'd300);
`else
      check("max_lower", 128'(aligned_ts), 128'd250);
`endif

      // Chain issue under backpressure
      bus.chain_in_valid = 1'b1;
      bus.parent_id = 128'd7;
      bus.parent_dist = 32'd5;
      bus.chain_out_ready = 1'b0;
      step();
      check("ch_out_valid", 128'(bus.chain_out_valid), 128'd1);
      check("ch_in_ready", 128'(bus.chain_in_ready), 128'd0);
      check("ch_id", bus.chain_id, 128'd8);
      check("ch_dist", 128'(bus.causal_distance), 128'd6);
      check("ch_sat", 128'(bus.causal_sat), 128'd0);
      bus.parent_id = 128'd99;
      bus.parent_dist = 32'd50;
      idle(2);
      check("ch_hold_id", bus.chain_id, 128'd8);
      check("ch_hold_dist", 128'(bus.causal_distance), 128'd6);
      check("ch_hold_valid", 128'(bus.chain_out_valid), 128'd1);
      check("ch_hold_ready", 128'(bus.chain_in_ready), 128'd0);
      bus.chain_in_valid = 1'b0;
      bus.chain_out_ready = 1'b1;
      step();
      bus.chain_out_ready = 1'b0;
      check("ch_rel_valid", 128'(bus.chain_out_valid), 128'd0);
      check("ch_rel_ready", 128'(bus.chain_in_ready), 128'd1);

      // Chain saturation at the ceiling, and the ID wraps
      bus.chain_in_valid = 1'b1;
      bus.parent_id = {128{1'b1}};
      bus.parent_dist = 32'd1000;
      step();
      bus.chain_in_valid = 1'b0;
      check("sat_dist", 128'(bus.causal_distance), 128'd1000);
      check("sat_flag", 128'(bus.causal_sat), 128'd1);
      check("sat_id_wrap", bus.chain_id, 128'd0);
      bus.chain_out_ready = 1'b1;
      step();
      bus.chain_out_ready = 1'b0;

      // One below the ceiling reaches it without the clamp flag
      bus.chain_in_valid = 1'b1;
      bus.parent_id = 128'd0;
      bus.parent_dist = 32'd999;
      step();
      bus.chain_in_valid = 1'b0;
      check("edge_dist", 128'(bus.causal_distance), 128'd1000);
      check("edge_flag", 128'(bus.causal_sat), 128'd0);
      check("edge_id", bus.chain_id, 128'd1);
      bus.chain_out_ready = 1'b1;
      step();
      bus.chain_out_ready = 1'b0;

      // Reset mid-operation with a pending child and a raised warning
      reset_dut();
      sample(0, 64'd0);
      idle(9);
      sample(0, 64'd500);
      check("mid_pre_warn", 128'(drift_warn[0]), 128'd1);
      check("mid_pre_drift", 128'(drift[31:0]), 128'd490);
      bus.chain_in_valid = 1'b1;
      bus.parent_id = 128'd3;
      bus.parent_dist = 32'd0;
      step();
      bus.chain_in_valid = 1'b0;
      check("mid_pre_out", 128'(bus.chain_out_valid), 128'd1);
      rst_n = 1'b0;
      #2;
      check("mid_out_valid", 128'(bus.chain_out_valid), 128'd0);
      check("mid_in_ready", 128'(bus.chain_in_ready), 128'd1);
      check("mid_chain_id", bus.chain_id, SEED);
      check("mid_warn", 128'(drift_warn), 128'd0);
      rst_n = 1'b1;
      step();
      sample(0, 64'd5000);
      check("post_first_drift", 128'(drift[31:0]), 128'd0);
      check("post_first_warn", 128'(drift_warn[0]), 128'd0);
      idle(9);
      sample(0, 64'd5110);
      check("post_thresh_drift", 128'(drift[31:0]), 128'd100);
      check("post_thresh_warn", 128'(drift_warn[0]), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
